// File: rtl/fault_campaign_ctrl_if.sv
// Handshake and status bundle between the campaign sequencer and its environment.
interface fault_campaign_ctrl_if;
    logic        start;
    logic        trig_in;
    logic        done_in;
    logic        soc_rstn;
    logic        inj_pulse;
    logic [4:0]  inj_bit;
    logic [2:0]  inj_reg_sel;
    logic        busy;
    logic        camp_done;
    logic [15:0] exp_idx;
    logic [15:0] cnt_inj;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_broken;

    // Sequencer side: drives target reset, injection strobe and campaign status.
    modport master (
        input  start, trig_in, done_in,
        output soc_rstn, inj_pulse, inj_bit, inj_reg_sel,
        output busy, camp_done, exp_idx, cnt_inj, cnt_ok, cnt_broken
    );

    // Host/target side: pulses start, reports AES running/finished, observes results.
    modport slave (
        output start, trig_in, done_in,
        input  soc_rstn, inj_pulse, inj_bit, inj_reg_sel,
        input  busy, camp_done, exp_idx, cnt_inj, cnt_ok, cnt_broken
    );
endinterface

// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: per experiment it resets the target, waits for
// the AES-running flag, optionally injects after an LFSR-drawn delay, and records the outcome.
module fault_campaign_ctrl #(
    parameter int unsigned NEXP      = 10,
    parameter int unsigned FR        = 70,
    parameter int unsigned TIMEOUT   = 32'h0000_C000,
    parameter int unsigned DELAY_MIN = 900,
    parameter logic [31:0] SEED      = 32'hACE1_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    fault_campaign_ctrl_if.master bus
);

    // Injection threshold on a 7-bit draw: FR=100 gives 128 (always), FR=0 gives 0 (never).
    localparam int unsigned INJ_THR   = (FR * 128) / 100;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;   // x^32+x^22+x^2+x+1
    localparam logic [15:0] LAST_IDX  = 16'(NEXP - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_HOLD,
        S_SETTLE,
        S_WAIT_TRIG,
        S_DELAY,
        S_WAIT_END,
        S_RECORD
    } state_e;

    state_e      state_q,     state_d;
    logic [1:0]  phase_q,     phase_d;
    logic [31:0] lfsr_q;
    logic [26:0] draw_q,      draw_d;
    logic [31:0] dly_q,       dly_d;
    logic [31:0] toc_q,       toc_d;
    logic        soc_rstn_q,  soc_rstn_d;
    logic        inj_pulse_q, inj_pulse_d;
    logic [4:0]  inj_bit_q,   inj_bit_d;
    logic [2:0]  inj_reg_q,   inj_reg_d;
    logic        busy_q,      busy_d;
    logic        camp_done_q, camp_done_d;
    logic [15:0] exp_idx_q,   exp_idx_d;
    logic [15:0] cnt_inj_q,   cnt_inj_d;
    logic [15:0] cnt_ok_q,    cnt_ok_d;
    logic [15:0] cnt_brk_q,   cnt_brk_d;

    logic        draw_inject_c;
    logic [31:0] draw_delay_c;
    logic [2:0]  draw_reg_c;
    logic        timeout_c;
    logic [31:0] toc_inc_c;
    logic        fire;
    logic        rec_ok;
    logic        rec_brk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

    // Decode of the per-experiment draw latched on entry to WAIT_TRIG.
    assign draw_inject_c = (32'(draw_q[6:0]) < INJ_THR);
    assign draw_delay_c  = DELAY_MIN + 32'(draw_q[18:7]);
    assign draw_reg_c    = (draw_q[26:24] == 3'd7) ? 3'd0 : draw_q[26:24];
    assign timeout_c     = (toc_q >= TIMEOUT);
    assign toc_inc_c     = (toc_q == 32'hFFFF_FFFF) ? toc_q : toc_q + 32'd1;

    // Free-running LFSR: one step every cycle out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    // State and registered outputs; reset aborts any campaign and clears all counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 2'd0;
            draw_q      <= 27'd0;
            dly_q       <= 32'd0;
            toc_q       <= 32'd0;
            soc_rstn_q  <= 1'b0;
            inj_pulse_q <= 1'b0;
            inj_bit_q   <= 5'd0;
            inj_reg_q   <= 3'd0;
            busy_q      <= 1'b0;
            camp_done_q <= 1'b0;
            exp_idx_q   <= 16'd0;
            cnt_inj_q   <= 16'd0;
            cnt_ok_q    <= 16'd0;
            cnt_brk_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            draw_q      <= draw_d;
            dly_q       <= dly_d;
            toc_q       <= toc_d;
            soc_rstn_q  <= soc_rstn_d;
            inj_pulse_q <= inj_pulse_d;
            inj_bit_q   <= inj_bit_d;
            inj_reg_q   <= inj_reg_d;
            busy_q      <= busy_d;
            camp_done_q <= camp_done_d;
            exp_idx_q   <= exp_idx_d;
            cnt_inj_q   <= cnt_inj_d;
            cnt_ok_q    <= cnt_ok_d;
            cnt_brk_q   <= cnt_brk_d;
        end
    end

    // Next-state and output logic; outcome counters update on the edge entering RECORD.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        draw_d      = draw_q;
        dly_d       = dly_q;
        toc_d       = toc_q;
        inj_pulse_d = 1'b0;
        inj_bit_d   = inj_bit_q;
        inj_reg_d   = inj_reg_q;
        busy_d      = busy_q;
        camp_done_d = 1'b0;
        exp_idx_d   = exp_idx_q;
        cnt_inj_d   = cnt_inj_q;
        cnt_ok_d    = cnt_ok_q;
        cnt_brk_d   = cnt_brk_q;
        fire        = 1'b0;
        rec_ok      = 1'b0;
        rec_brk     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d    = 1'b1;
                    exp_idx_d = 16'd0;
                    cnt_inj_d = 16'd0;
                    cnt_ok_d  = 16'd0;
                    cnt_brk_d = 16'd0;
                    phase_d   = 2'd0;
                    state_d   = S_RST_HOLD;
                end
            end
            S_RST_HOLD: begin
                if (phase_q == 2'd2) begin
                    phase_d = 2'd0;
                    state_d = S_SETTLE;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            S_SETTLE: begin
                if (phase_q == 2'd1) begin
                    phase_d = 2'd0;
                    draw_d  = lfsr_q[26:0];
                    state_d = S_WAIT_TRIG;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            S_WAIT_TRIG: begin
                if (bus.trig_in) begin
                    // toc counts cycles since the trigger cycle; it reads 1 one cycle later.
                    toc_d = 32'd1;
                    if (!draw_inject_c) begin
                        state_d = S_WAIT_END;
                    end else if (draw_delay_c == 32'd0) begin
                        fire    = 1'b1;
                        state_d = S_WAIT_END;
                    end else begin
                        dly_d   = draw_delay_c;
                        state_d = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                toc_d = toc_inc_c;
                if (bus.done_in) begin
                    rec_ok = 1'b1;
                end else if (timeout_c) begin
                    rec_brk = 1'b1;
                end else if (dly_q == 32'd1) begin
                    fire    = 1'b1;
                    state_d = S_WAIT_END;
                end else begin
                    dly_d = dly_q - 32'd1;
                end
            end
            S_WAIT_END: begin
                toc_d = toc_inc_c;
                if (bus.done_in) begin
                    rec_ok = 1'b1;
                end else if (timeout_c) begin
                    rec_brk = 1'b1;
                end
            end
            S_RECORD: begin
                if (exp_idx_q == LAST_IDX) begin
                    camp_done_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    exp_idx_d = exp_idx_q + 16'd1;
                    phase_d   = 2'd0;
                    state_d   = S_RST_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fire) begin
            inj_pulse_d = 1'b1;
            inj_bit_d   = draw_q[23:19];
            inj_reg_d   = draw_reg_c;
            cnt_inj_d   = sat_inc(cnt_inj_q);
        end
        if (rec_ok) begin
            cnt_ok_d = sat_inc(cnt_ok_q);
            state_d  = S_RECORD;
        end
        if (rec_brk) begin
            cnt_brk_d = sat_inc(cnt_brk_q);
            state_d   = S_RECORD;
        end
    end

    // Target is held in reset exactly while the FSM sits in RST_HOLD.
    assign soc_rstn_d = (state_d != S_RST_HOLD);

    assign bus.soc_rstn    = soc_rstn_q;
    assign bus.inj_pulse   = inj_pulse_q;
    assign bus.inj_bit     = inj_bit_q;
    assign bus.inj_reg_sel = inj_reg_q;
    assign bus.busy        = busy_q;
    assign bus.camp_done   = camp_done_q;
    assign bus.exp_idx     = exp_idx_q;
    assign bus.cnt_inj     = cnt_inj_q;
    assign bus.cnt_ok      = cnt_ok_q;
    assign bus.cnt_broken  = cnt_brk_q;

endmodule
